reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Tomasulo-style reservation station directly upstream of the reorder buffer's CDB input.
- Holds issued instructions, keyed by their ROB tag, until both source operands are available, and snoops the CDB for operand values.
- Dispatches ready instructions to a single execute unit; the execute unit's result returns on the CDB to the ROB and back into this block.

Parameters:
- RS_SIZE, 4, number of entries (power of two, 2..8).
- TAG_W, 5, ROB tag width.
- NONE, 5'b11111, reserved tag meaning "operand already valid / no producer".
- OP_W, 4, opcode width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all entries (mispredict recovery).
- issue_valid  input  1  issue request this cycle.
- issue_ready  output  1  at least one free entry.
- issue_op  input  OP_W  opcode.
- issue_rob_tag  input  TAG_W  destination ROB tag (the ROB's alloc_tag).
- issue_q1  input  TAG_W  producer tag of src1; NONE means issue_v1 is valid.
- issue_v1  input  32  src1 value.
- issue_q2  input  TAG_W  producer tag of src2; NONE means issue_v2 is valid.
- issue_v2  input  32  src2 value.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_W  broadcasting ROB tag.
- cdb_val  input  32  broadcast result.
- disp_valid  output  1  a ready entry is presented.
- disp_ready  input  1  execute unit accepts.
- disp_op  output  OP_W  opcode of presented entry.
- disp_v1  output  32  src1 value.
- disp_v2  output  32  src2 value.
- disp_rob_tag  output  TAG_W  ROB tag of presented entry.
- occupancy  output  log2(RS_SIZE)+1  number of valid entries.

Behaviour:
- Entry state: busy, op, rob_tag, q1, v1, q2, v2. An entry is ready when busy && q1==NONE && q2==NONE.
- Reset (reset=1 at edge): all busy=0, q1/q2=NONE. Outputs after reset: issue_ready=1, disp_valid=0, occupancy=0, disp_op/v1/v2=0, disp_rob_tag=NONE.
- Priority: reset > flush > normal operation. flush clears all busy bits at the edge; any issue or dispatch in the same cycle is discarded.
- issue_ready = (occupancy < RS_SIZE), combinational from registered state only. A slot freed by dispatch in cycle N is not reusable by an issue in the same cycle N; it is reusable from N+1.
- Issue is accepted when issue_valid && issue_ready. The data is written into the lowest-index free entry. When !issue_ready, issue_valid is ignored and no state changes.
- CDB capture: when cdb_valid && cdb_tag!=NONE, every busy entry with q1==cdb_tag loads v1=cdb_val and q1=NONE; same for q2/v2.
- Issue bypass: if an issued operand's tag equals a valid same-cycle CDB tag, the entry is written with the CDB value and q=NONE. The CDB is never missed.
- A CDB tag of NONE is ignored. Broadcasts for tags held by no entry have no effect.
- Dispatch select is combinational: the lowest-index ready entry drives disp_*, and disp_valid=1. When no entry is ready, disp_valid=0 and disp_* hold their last values (not X).
- An entry that becomes ready through CDB capture at edge N is eligible for dispatch in the cycle after edge N. There is no combinational CDB-to-dispatch path.
- Dispatch handshake: when disp_valid && disp_ready at an edge, the selected entry's busy is cleared. While disp_valid && !disp_ready, disp_* must stay stable unless a lower-index entry becomes ready.
- Simultaneous issue, dispatch and CDB in one cycle are all honoured. occupancy updates as +1 for an accepted issue, -1 for a completed dispatch, net 0 when both occur.
- Wrap/boundary: when occupancy==RS_SIZE, issue_ready=0. occupancy never exceeds RS_SIZE or underflows.
- Mid-operation reset or flush empties the station within one edge. A CDB broadcast in that same cycle is dropped.

Test Plan:
- Reset: hold reset 2 cycles → issue_ready=1, disp_valid=0, occupancy=0, disp_rob_tag=5'b11111.
- Ready-at-issue: issue op=3, tag=2, q1=q2=NONE, v1=5, v2=7 with disp_ready=1 → next cycle disp_valid=1, disp_v1=5, disp_v2=7, disp_rob_tag=2; one cycle later occupancy=0.
- CDB wakeup: issue tag=4, q1=1, v2=9 (q2=NONE); two cycles later CDB tag=1, val=0x100 → disp_valid=1 one cycle after the broadcast with disp_v1=0x100.
- Issue/CDB bypass: issue q2=6 in the same cycle as CDB tag=6, val=0xABCD → entry dispatches the next cycle with disp_v2=0xABCD.
- Full and backpressure: with disp_ready=0, fill 4 entries (tags 0..3) → issue_ready=0 and a 5th issue is ignored. Raise disp_ready for 1 cycle → tag 0 leaves, issue_ready=1 the next cycle, and the new issue lands in entry 0.
- Flush: with 3 entries busy, assert flush together with issue_valid → next cycle occupancy=0, disp_valid=0, and the flushed-cycle issue is absent.

Source files
------------

// File: rtl/reservation_station_if.sv
// reservation_station_if: issue, CDB snoop and dispatch bundle of the reservation station
interface reservation_station_if #(
  parameter int RS_SIZE = 4,
  parameter int TAG_W = 5,
  parameter int OP_W = 4
);
  logic flush;
  logic issue_valid;
  logic issue_ready;
  logic [OP_W-1:0] issue_op;
  logic [TAG_W-1:0] issue_rob_tag;
  logic [TAG_W-1:0] issue_q1;
  logic [31:0] issue_v1;
  logic [TAG_W-1:0] issue_q2;
  logic [31:0] issue_v2;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0] cdb_val;
  logic disp_valid;
  logic disp_ready;
  logic [OP_W-1:0] disp_op;
  logic [31:0] disp_v1;
  logic [31:0] disp_v2;
  logic [TAG_W-1:0] disp_rob_tag;
  logic [$clog2(RS_SIZE):0] occupancy;
  modport master (
    output flush, issue_valid, issue_op, issue_rob_tag, issue_q1, issue_v1, issue_q2, issue_v2,
    output cdb_valid, cdb_tag, cdb_val, disp_ready,
    input issue_ready, disp_valid, disp_op, disp_v1, disp_v2, disp_rob_tag, occupancy
  );
  modport slave (
    input flush, issue_valid, issue_op, issue_rob_tag, issue_q1, issue_v1, issue_q2, issue_v2,
    input cdb_valid, cdb_tag, cdb_val, disp_ready,
    output issue_ready, disp_valid, disp_op, disp_v1, disp_v2, disp_rob_tag, occupancy
  );
endinterface

// File: rtl/reservation_station.sv
// reservation_station: tag-keyed operand wait buffer with CDB snooping and lowest-index dispatch
module reservation_station #(
  parameter int RS_SIZE = 4,
  parameter int TAG_W = 5,
  parameter int OP_W = 4,
  parameter logic [TAG_W-1:0] NONE = '1
) (
  input logic clk,
  input logic reset,
  reservation_station_if.slave bus
);
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [OP_W-1:0] op_q [RS_SIZE];
  logic [OP_W-1:0] op_d [RS_SIZE];
  logic [TAG_W-1:0] tag_q [RS_SIZE];
  logic [TAG_W-1:0] tag_d [RS_SIZE];
  logic [TAG_W-1:0] q1_q [RS_SIZE];
  logic [TAG_W-1:0] q1_d [RS_SIZE];
  logic [TAG_W-1:0] q2_q [RS_SIZE];
  logic [TAG_W-1:0] q2_d [RS_SIZE];
  logic [31:0] v1_q [RS_SIZE];
  logic [31:0] v1_d [RS_SIZE];
  logic [31:0] v2_q [RS_SIZE];
  logic [31:0] v2_d [RS_SIZE];
  logic [OP_W-1:0] last_op_q, last_op_d;
  logic [TAG_W-1:0] last_tag_q, last_tag_d;
  logic [31:0] last_v1_q, last_v1_d, last_v2_q, last_v2_d;
  logic [IW-1:0] sel, free;
  logic rdy, cdb_hit;
  logic [IW:0] occ;
  always_comb begin
    busy_d = busy_q;
    op_d = op_q;
    tag_d = tag_q;
    q1_d = q1_q;
    q2_d = q2_q;
    v1_d = v1_q;
    v2_d = v2_q;
    rdy = 1'b0;
    sel = '0;
    free = '0;
    occ = '0;
    cdb_hit = bus.cdb_valid && bus.cdb_tag != NONE;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy_q[i] && q1_q[i] == NONE && q2_q[i] == NONE) begin
        rdy = 1'b1;
        sel = IW'(i);
      end
      if (!busy_q[i]) free = IW'(i);
      occ = occ + (IW+1)'(busy_q[i]);
      if (busy_q[i] && cdb_hit && q1_q[i] == bus.cdb_tag) begin
        q1_d[i] = NONE;
        v1_d[i] = bus.cdb_val;
      end
      if (busy_q[i] && cdb_hit && q2_q[i] == bus.cdb_tag) begin
        q2_d[i] = NONE;
        v2_d[i] = bus.cdb_val;
      end
    end
    if (rdy && bus.disp_ready) busy_d[sel] = 1'b0;
    if (bus.issue_valid && !(&busy_q)) begin
      busy_d[free] = 1'b1;
      op_d[free] = bus.issue_op;
      tag_d[free] = bus.issue_rob_tag;
      q1_d[free] = (cdb_hit && bus.issue_q1 == bus.cdb_tag) ? NONE : bus.issue_q1;
      v1_d[free] = (cdb_hit && bus.issue_q1 == bus.cdb_tag) ? bus.cdb_val : bus.issue_v1;
      q2_d[free] = (cdb_hit && bus.issue_q2 == bus.cdb_tag) ? NONE : bus.issue_q2;
      v2_d[free] = (cdb_hit && bus.issue_q2 == bus.cdb_tag) ? bus.cdb_val : bus.issue_v2;
    end
    if (bus.flush) busy_d = '0;
    last_op_d = rdy ? op_q[sel] : last_op_q;
    last_tag_d = rdy ? tag_q[sel] : last_tag_q;
    last_v1_d = rdy ? v1_q[sel] : last_v1_q;
    last_v2_d = rdy ? v2_q[sel] : last_v2_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i] <= '0;
        tag_q[i] <= NONE;
        q1_q[i] <= NONE;
        q2_q[i] <= NONE;
        v1_q[i] <= '0;
        v2_q[i] <= '0;
      end
      last_op_q <= '0;
      last_tag_q <= NONE;
      last_v1_q <= '0;
      last_v2_q <= '0;
    end else begin
      busy_q <= busy_d;
      op_q <= op_d;
      tag_q <= tag_d;
      q1_q <= q1_d;
      q2_q <= q2_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      last_op_q <= last_op_d;
      last_tag_q <= last_tag_d;
      last_v1_q <= last_v1_d;
      last_v2_q <= last_v2_d;
    end
  end
  assign bus.issue_ready = ~&busy_q;
  assign bus.occupancy = occ;
  assign bus.disp_valid = rdy;
  assign bus.disp_op = last_op_d;
  assign bus.disp_rob_tag = last_tag_d;
  assign bus.disp_v1 = last_v1_d;
  assign bus.disp_v2 = last_v2_d;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenario tests for reservation_station
module tb_reservation_station;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  localparam logic [4:0] NONE = 5'b11111;
  reservation_station_if #(.RS_SIZE(4), .TAG_W(5), .OP_W(4)) bus ();
  reservation_station dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_op = '0;
    bus.issue_rob_tag = '0;
    bus.issue_q1 = NONE;
    bus.issue_v1 = '0;
    bus.issue_q2 = NONE;
    bus.issue_v2 = '0;
    bus.cdb_valid = 1'b0;
    bus.cdb_tag = NONE;
    bus.cdb_val = '0;
  endtask
  task automatic do_issue(input logic [3:0] op, input logic [4:0] tag, input logic [4:0] q1,
                          input logic [31:0] v1, input logic [4:0] q2, input logic [31:0] v2);
    bus.issue_valid = 1'b1;
    bus.issue_op = op;
    bus.issue_rob_tag = tag;
    bus.issue_q1 = q1;
    bus.issue_v1 = v1;
    bus.issue_q2 = q2;
    bus.issue_v2 = v2;
  endtask
  task automatic test_reset();
    idle();
    bus.disp_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL reset_issue_ready got %0h want 1", bus.issue_ready); end
    tests++; if (bus.disp_valid !== 1'b0) begin fails++; $display("FAIL reset_disp_valid got %0h want 0", bus.disp_valid); end
    tests++; if (bus.occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    tests++; if (bus.disp_rob_tag !== NONE) begin fails++; $display("FAIL reset_disp_rob_tag got %0h want 1f", bus.disp_rob_tag); end
    tests++; if (bus.disp_v1 !== 32'd0 || bus.disp_v2 !== 32'd0 || bus.disp_op !== 4'd0) begin fails++; $display("FAIL reset_disp_data got %0h/%0h/%0h want 0/0/0", bus.disp_op, bus.disp_v1, bus.disp_v2); end
  endtask
  task automatic test_ready_at_issue();
    bus.disp_ready = 1'b1;
    do_issue(4'd3, 5'd2, NONE, 32'd5, NONE, 32'd7);
    step();
    idle();
    tests++; if (bus.disp_valid !== 1'b1) begin fails++; $display("FAIL rai_disp_valid got %0h want 1", bus.disp_valid); end
    tests++; if (bus.disp_v1 !== 32'd5 || bus.disp_v2 !== 32'd7) begin fails++; $display("FAIL rai_values got %0h/%0h want 5/7", bus.disp_v1, bus.disp_v2); end
    tests++; if (bus.disp_rob_tag !== 5'd2 || bus.disp_op !== 4'd3) begin fails++; $display("FAIL rai_tag_op got %0h/%0h want 2/3", bus.disp_rob_tag, bus.disp_op); end
    tests++; if (bus.occupancy !== 3'd1) begin fails++; $display("FAIL rai_occ_1 got %0d want 1", bus.occupancy); end
    step();
    tests++; if (bus.occupancy !== 3'd0 || bus.disp_valid !== 1'b0) begin fails++; $display("FAIL rai_drained got occ %0d valid %0h want 0/0", bus.occupancy, bus.disp_valid); end
    tests++; if (bus.disp_rob_tag !== 5'd2 || bus.disp_v1 !== 32'd5) begin fails++; $display("FAIL rai_hold got %0h/%0h want 2/5", bus.disp_rob_tag, bus.disp_v1); end
  endtask
  task automatic test_cdb_wakeup();
    bus.disp_ready = 1'b1;
    do_issue(4'd5, 5'd4, 5'd1, 32'd0, NONE, 32'd9);
    step();
    idle();
    tests++; if (bus.disp_valid !== 1'b0 || bus.occupancy !== 3'd1) begin fails++; $display("FAIL cdb_waiting got valid %0h occ %0d want 0/1", bus.disp_valid, bus.occupancy); end
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = NONE;
    bus.cdb_val = 32'hDEAD;
    step();
    bus.cdb_tag = 5'd9;
    step();
    bus.cdb_valid = 1'b0;
    tests++; if (bus.disp_valid !== 1'b0) begin fails++; $display("FAIL cdb_ignore_none_unrelated got %0h want 0", bus.disp_valid); end
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = 5'd1;
    bus.cdb_val = 32'h100;
    step();
    idle();
    tests++; if (bus.disp_valid !== 1'b1 || bus.disp_rob_tag !== 5'd4) begin fails++; $display("FAIL cdb_wake got valid %0h tag %0h want 1/4", bus.disp_valid, bus.disp_rob_tag); end
    tests++; if (bus.disp_v1 !== 32'h100 || bus.disp_v2 !== 32'd9) begin fails++; $display("FAIL cdb_values got %0h/%0h want 100/9", bus.disp_v1, bus.disp_v2); end
    step();
    tests++; if (bus.occupancy !== 3'd0) begin fails++; $display("FAIL cdb_drained got %0d want 0", bus.occupancy); end
  endtask
  task automatic test_bypass();
    bus.disp_ready = 1'b1;
    do_issue(4'd1, 5'd8, NONE, 32'd1, 5'd6, 32'd0);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = 5'd6;
    bus.cdb_val = 32'hABCD;
    step();
    idle();
    tests++; if (bus.disp_valid !== 1'b1 || bus.disp_rob_tag !== 5'd8) begin fails++; $display("FAIL byp_valid got valid %0h tag %0h want 1/8", bus.disp_valid, bus.disp_rob_tag); end
    tests++; if (bus.disp_v2 !== 32'hABCD || bus.disp_v1 !== 32'd1) begin fails++; $display("FAIL byp_values got %0h/%0h want 1/abcd", bus.disp_v1, bus.disp_v2); end
    step();
    tests++; if (bus.occupancy !== 3'd0) begin fails++; $display("FAIL byp_drained got %0d want 0", bus.occupancy); end
  endtask
  task automatic test_full_backpressure();
    bus.disp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_issue(4'd2, 5'(i), NONE, 32'(i * 16), NONE, 32'(i));
      step();
    end
    do_issue(4'd7, 5'd9, NONE, 32'h99, NONE, 32'h98);
    tests++; if (bus.occupancy !== 3'd4 || bus.issue_ready !== 1'b0) begin fails++; $display("FAIL full_state got occ %0d ready %0h want 4/0", bus.occupancy, bus.issue_ready); end
    tests++; if (bus.disp_valid !== 1'b1 || bus.disp_rob_tag !== 5'd0) begin fails++; $display("FAIL full_head got valid %0h tag %0h want 1/0", bus.disp_valid, bus.disp_rob_tag); end
    step();
    tests++; if (bus.occupancy !== 3'd4 || bus.disp_rob_tag !== 5'd0) begin fails++; $display("FAIL full_ignore got occ %0d tag %0h want 4/0", bus.occupancy, bus.disp_rob_tag); end
    bus.disp_ready = 1'b1;
    step();
    bus.disp_ready = 1'b0;
    tests++; if (bus.occupancy !== 3'd3 || bus.issue_ready !== 1'b1) begin fails++; $display("FAIL full_freed got occ %0d ready %0h want 3/1", bus.occupancy, bus.issue_ready); end
    tests++; if (bus.disp_rob_tag !== 5'd1 || bus.disp_v1 !== 32'h10) begin fails++; $display("FAIL full_next got tag %0h v1 %0h want 1/10", bus.disp_rob_tag, bus.disp_v1); end
    step();
    idle();
    tests++; if (bus.occupancy !== 3'd4 || bus.disp_rob_tag !== 5'd9 || bus.disp_op !== 4'd7) begin fails++; $display("FAIL full_refill_entry0 got occ %0d tag %0h op %0h want 4/9/7", bus.occupancy, bus.disp_rob_tag, bus.disp_op); end
    bus.disp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    tests++; if (bus.occupancy !== 3'd0 || bus.disp_valid !== 1'b0) begin fails++; $display("FAIL full_drain got occ %0d valid %0h want 0/0", bus.occupancy, bus.disp_valid); end
  endtask
  task automatic test_flush();
    bus.disp_ready = 1'b0;
    do_issue(4'd1, 5'd10, NONE, 32'd1, NONE, 32'd2);
    step();
    do_issue(4'd1, 5'd11, 5'd20, 32'd0, NONE, 32'd3);
    step();
    do_issue(4'd1, 5'd12, NONE, 32'd4, NONE, 32'd5);
    step();
    tests++; if (bus.occupancy !== 3'd3) begin fails++; $display("FAIL flush_pre_occ got %0d want 3", bus.occupancy); end
    do_issue(4'd1, 5'd13, NONE, 32'd6, NONE, 32'd7);
    bus.flush = 1'b1;
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = 5'd20;
    bus.cdb_val = 32'h77;
    step();
    idle();
    tests++; if (bus.occupancy !== 3'd0 || bus.disp_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin fails++; $display("FAIL flush_empty got occ %0d valid %0h ready %0h want 0/0/1", bus.occupancy, bus.disp_valid, bus.issue_ready); end
    step();
    tests++; if (bus.occupancy !== 3'd0 || bus.disp_valid !== 1'b0) begin fails++; $display("FAIL flush_issue_dropped got occ %0d valid %0h want 0/0", bus.occupancy, bus.disp_valid); end
  endtask
  task automatic test_back_to_back();
    bus.disp_ready = 1'b0;
    do_issue(4'd4, 5'd2, 5'd30, 32'd0, NONE, 32'd3);
    step();
    do_issue(4'd6, 5'd1, NONE, 32'd1, NONE, 32'd2);
    step();
    tests++; if (bus.occupancy !== 3'd2 || bus.disp_rob_tag !== 5'd1) begin fails++; $display("FAIL b2b_skip_unready got occ %0d tag %0h want 2/1", bus.occupancy, bus.disp_rob_tag); end
    bus.disp_ready = 1'b1;
    do_issue(4'd8, 5'd3, NONE, 32'd7, NONE, 32'd8);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = 5'd30;
    bus.cdb_val = 32'h55;
    step();
    idle();
    tests++; if (bus.occupancy !== 3'd2) begin fails++; $display("FAIL b2b_net_occ got %0d want 2", bus.occupancy); end
    tests++; if (bus.disp_rob_tag !== 5'd2 || bus.disp_v1 !== 32'h55 || bus.disp_v2 !== 32'd3) begin fails++; $display("FAIL b2b_woken got tag %0h v1 %0h v2 %0h want 2/55/3", bus.disp_rob_tag, bus.disp_v1, bus.disp_v2); end
    step();
    tests++; if (bus.disp_rob_tag !== 5'd3 || bus.disp_v1 !== 32'd7 || bus.occupancy !== 3'd1) begin fails++; $display("FAIL b2b_third got tag %0h v1 %0h occ %0d want 3/7/1", bus.disp_rob_tag, bus.disp_v1, bus.occupancy); end
    step();
    tests++; if (bus.occupancy !== 3'd0) begin fails++; $display("FAIL b2b_drained got %0d want 0", bus.occupancy); end
  endtask
  initial begin
    test_reset();
    test_ready_at_issue();
    test_cdb_wakeup();
    test_bypass();
    test_full_backpressure();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
